// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - FWFT receive FIFO behind uart_core with overflow and parity-error tracking
// Each entry is {err, data}. Outputs are forced to zero while the FIFO is empty.
module uart_rx_fifo #(
   parameter  int DEPTH = 8,
   parameter  int WIDTH = 8,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             wr_valid,
   input  logic             wr_err,
   input  logic             rd_req,
   output logic [WIDTH-1:0] rd_data,
   output logic             rd_err,
   output logic             rd_valid,
   output logic             full,
   output logic [AW:0]      count,
   output logic             overflow,
   input  logic             clr_ovf,
   output logic [7:0]       err_cnt
);

   localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

   logic [WIDTH:0]  mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic            push;
   logic            pop;
   logic [WIDTH:0]  head;

   assign rd_valid = (count != '0);
   assign full     = (count == FULL_COUNT);

   // A pop in the same cycle frees the slot, so a full FIFO still accepts the write.
   assign push = wr_valid & (~full | rd_req);
   assign pop  = rd_req & rd_valid;

   assign head    = mem[rd_ptr];
   assign rd_data = rd_valid ? head[WIDTH-1:0] : '0;
   assign rd_err  = rd_valid ? head[WIDTH]     : 1'b0;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
         err_cnt  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= {wr_err, wr_data};
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (push && !pop) begin
            count <= count + 1'b1;
         end else if (pop && !push) begin
            count <= count - 1'b1;
         end
         // Setting beats clearing so a drop in the clear cycle is never lost.
         if (wr_valid && full && !rd_req) begin
            overflow <= 1'b1;
         end else if (clr_ovf) begin
            overflow <= 1'b0;
         end
         if (push && wr_err && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - directed self-checking bench for uart_rx_fifo
module tb_uart_rx_fifo;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] wr_data;
   logic       wr_valid;
   logic       wr_err;
   logic       rd_req;
   logic [7:0] rd_data;
   logic       rd_err;
   logic       rd_valid;
   logic       full;
   logic [3:0] count;
   logic       overflow;
   logic       clr_ovf;
   logic [7:0] err_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   uart_rx_fifo #(.DEPTH(8), .WIDTH(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .wr_data  (wr_data),
      .wr_valid (wr_valid),
      .wr_err   (wr_err),
      .rd_req   (rd_req),
      .rd_data  (rd_data),
      .rd_err   (rd_err),
      .rd_valid (rd_valid),
      .full     (full),
      .count    (count),
      .overflow (overflow),
      .clr_ovf  (clr_ovf),
      .err_cnt  (err_cnt)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_byte(input logic [7:0] d, input logic e);
      wr_data  = d;
      wr_err   = e;
      wr_valid = 1'b1;
      step();
      wr_valid = 1'b0;
      wr_err   = 1'b0;
   endtask

   task automatic pop_one();
      rd_req = 1'b1;
      step();
      rd_req = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rd_valid got %0b want 0", rd_valid); end
      n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL reset_count got %0d want 0", count); end
      n_cmp++; if (full !== 1'b0) begin n_bad++; $display("FAIL reset_full got %0b want 0", full); end
      n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_overflow got %0b want 0", overflow); end
      n_cmp++; if (err_cnt !== 8'd0) begin n_bad++; $display("FAIL reset_err_cnt got %0d want 0", err_cnt); end
      n_cmp++; if (rd_data !== 8'h00) begin n_bad++; $display("FAIL reset_rd_data got %h want 00", rd_data); end
      n_cmp++; if (rd_err !== 1'b0) begin n_bad++; $display("FAIL reset_rd_err got %0b want 0", rd_err); end
      rd_req = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         n_cmp++; if (count !== 4'd0 || rd_valid !== 1'b0 || rd_data !== 8'h00) begin
            n_bad++; $display("FAIL empty_read cyc%0d count=%0d rd_valid=%0b rd_data=%h want 0/0/00", i, count, rd_valid, rd_data);
         end
      end
      rd_req = 1'b0;
   endtask

   task automatic test_single();
      push_byte(8'hA5, 1'b0);
      n_cmp++; if (rd_valid !== 1'b1 || rd_data !== 8'hA5 || count !== 4'd1) begin
         n_bad++; $display("FAIL single_write rd_valid=%0b rd_data=%h count=%0d want 1/a5/1", rd_valid, rd_data, count);
      end
      pop_one();
      n_cmp++; if (rd_valid !== 1'b0 || count !== 4'd0 || rd_data !== 8'h00) begin
         n_bad++; $display("FAIL single_pop rd_valid=%0b count=%0d rd_data=%h want 0/0/00", rd_valid, count, rd_data);
      end
   endtask

   task automatic test_fill_order(input logic [7:0] base);
      for (int i = 0; i < 8; i++) push_byte(base + 8'(i), 1'b0);
      n_cmp++; if (full !== 1'b1 || count !== 4'd8) begin
         n_bad++; $display("FAIL fill_%h full=%0b count=%0d want 1/8", base, full, count);
      end
      for (int i = 0; i < 8; i++) begin
         n_cmp++; if (rd_valid !== 1'b1 || rd_data !== base + 8'(i)) begin
            n_bad++; $display("FAIL order_%h_%0d rd_valid=%0b rd_data=%h want 1/%h", base, i, rd_valid, rd_data, base + 8'(i));
         end
         pop_one();
      end
      n_cmp++; if (rd_valid !== 1'b0 || count !== 4'd0) begin
         n_bad++; $display("FAIL drain_%h rd_valid=%0b count=%0d want 0/0", base, rd_valid, count);
      end
   endtask

   task automatic test_overflow();
      do_reset();
      for (int i = 1; i <= 8; i++) push_byte(8'(i), 1'b0);
      push_byte(8'hFF, 1'b0);
      n_cmp++; if (overflow !== 1'b1 || count !== 4'd8 || rd_data !== 8'h01) begin
         n_bad++; $display("FAIL overflow_set overflow=%0b count=%0d head=%h want 1/8/01", overflow, count, rd_data);
      end
      clr_ovf = 1'b1;
      push_byte(8'hFE, 1'b0);
      n_cmp++; if (overflow !== 1'b1 || count !== 4'd8) begin
         n_bad++; $display("FAIL overflow_set_wins overflow=%0b count=%0d want 1/8", overflow, count);
      end
      step();
      clr_ovf = 1'b0;
      n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL overflow_clear got %0b want 0", overflow); end
      n_cmp++; if (err_cnt !== 8'd0) begin n_bad++; $display("FAIL overflow_err_cnt got %0d want 0", err_cnt); end
   endtask

   task automatic test_back_to_back();
      // still full with 01..08 from the overflow scenario
      wr_data = 8'h55; wr_valid = 1'b1; rd_req = 1'b1;
      step();
      wr_valid = 1'b0; rd_req = 1'b0;
      n_cmp++; if (count !== 4'd8 || rd_data !== 8'h02 || overflow !== 1'b0 || full !== 1'b1) begin
         n_bad++; $display("FAIL full_rw count=%0d head=%h overflow=%0b full=%0b want 8/02/0/1", count, rd_data, overflow, full);
      end
      for (int i = 2; i <= 8; i++) begin
         n_cmp++; if (rd_data !== 8'(i)) begin n_bad++; $display("FAIL full_rw_order_%0d got %h want %h", i, rd_data, 8'(i)); end
         pop_one();
      end
      n_cmp++; if (rd_data !== 8'h55 || count !== 4'd1) begin
         n_bad++; $display("FAIL full_rw_last rd_data=%h count=%0d want 55/1", rd_data, count);
      end
      pop_one();
      wr_data = 8'h33; wr_valid = 1'b1; rd_req = 1'b1;
      step();
      wr_valid = 1'b0; rd_req = 1'b0;
      n_cmp++; if (count !== 4'd1 || rd_data !== 8'h33 || rd_valid !== 1'b1) begin
         n_bad++; $display("FAIL empty_rw count=%0d rd_data=%h rd_valid=%0b want 1/33/1", count, rd_data, rd_valid);
      end
      pop_one();
   endtask

   task automatic test_err_tag();
      do_reset();
      push_byte(8'h10, 1'b1);
      push_byte(8'h20, 1'b0);
      n_cmp++; if (err_cnt !== 8'd1) begin n_bad++; $display("FAIL err_cnt_one got %0d want 1", err_cnt); end
      n_cmp++; if (rd_err !== 1'b1 || rd_data !== 8'h10) begin
         n_bad++; $display("FAIL err_tag_first rd_err=%0b rd_data=%h want 1/10", rd_err, rd_data);
      end
      pop_one();
      n_cmp++; if (rd_err !== 1'b0 || rd_data !== 8'h20) begin
         n_bad++; $display("FAIL err_tag_second rd_err=%0b rd_data=%h want 0/20", rd_err, rd_data);
      end
      pop_one();
      wr_data = 8'hEE; wr_err = 1'b1; wr_valid = 1'b1; rd_req = 1'b1;
      for (int i = 0; i < 300; i++) begin
         step();
         if (i == 99) begin
            n_cmp++; if (err_cnt !== 8'd101) begin n_bad++; $display("FAIL err_cnt_mid got %0d want 101", err_cnt); end
         end
      end
      wr_valid = 1'b0; wr_err = 1'b0; rd_req = 1'b0;
      n_cmp++; if (err_cnt !== 8'd255 || count !== 4'd1) begin
         n_bad++; $display("FAIL err_cnt_sat err_cnt=%0d count=%0d want 255/1", err_cnt, count);
      end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 9; i++) push_byte(8'hC0 + 8'(i), 1'b1);
      n_cmp++; if (overflow !== 1'b1 || full !== 1'b1) begin
         n_bad++; $display("FAIL pre_reset overflow=%0b full=%0b want 1/1", overflow, full);
      end
      rst = 1'b1; wr_data = 8'h77; wr_valid = 1'b1; wr_err = 1'b1;
      step();
      rst = 1'b0; wr_valid = 1'b0; wr_err = 1'b0;
      n_cmp++; if (count !== 4'd0 || rd_valid !== 1'b0 || overflow !== 1'b0 || err_cnt !== 8'd0 || rd_data !== 8'h00) begin
         n_bad++; $display("FAIL reset_mid count=%0d rd_valid=%0b overflow=%0b err_cnt=%0d rd_data=%h want 0/0/0/0/00",
                           count, rd_valid, overflow, err_cnt, rd_data);
      end
   endtask

   initial begin
      rst = 1'b0; wr_data = 8'h00; wr_valid = 1'b0; wr_err = 1'b0; rd_req = 1'b0; clr_ovf = 1'b0;
      test_reset();
      test_single();
      test_fill_order(8'h01);
      test_fill_order(8'h10);
      test_overflow();
      test_back_to_back();
      test_err_tag();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
